// File: rtl/cpu6502_pkg.sv
// Shared 6502 core constants: address-source and index-select encodings and default page bytes.
package cpu6502_pkg;

  localparam logic [7:0] DEF_ZP_PAGE    = 8'h00;
  localparam logic [7:0] DEF_STACK_PAGE = 8'h01;
  localparam logic [7:0] DEF_VEC_PAGE   = 8'hFF;

  localparam logic [3:0] SRC_PC      = 4'd0;
  localparam logic [3:0] SRC_ZP      = 4'd1;
  localparam logic [3:0] SRC_ABS     = 4'd2;
  localparam logic [3:0] SRC_ZPTR_LO = 4'd3;
  localparam logic [3:0] SRC_ZPTR_HI = 4'd4;
  localparam logic [3:0] SRC_IND     = 4'd5;
  localparam logic [3:0] SRC_STACK   = 4'd6;
  localparam logic [3:0] SRC_VECTOR  = 4'd7;
  localparam logic [3:0] SRC_IND_HI  = 4'd8;

  localparam logic [1:0] IDX_NONE     = 2'b00;
  localparam logic [1:0] IDX_X        = 2'b01;
  localparam logic [1:0] IDX_Y        = 2'b10;
  localparam logic [1:0] IDX_NONE_ALT = 2'b11;

  // Only the 16-bit-base sources may need the extra high-byte cycle.
  function automatic logic is_fixup_src(input logic [3:0] s);
    return (s == SRC_ABS) || (s == SRC_IND);
  endfunction

endpackage

// File: rtl/address_gen_if.sv
// Request/response bundle between the sequencer (master) and the address generator (slave).
interface address_gen_if #(
  parameter int DATA_W = 8
) ();

  logic                  req;
  logic [3:0]            src;
  logic [1:0]            idx_sel;
  logic                  always_fix;
  logic [2*DATA_W-1:0]   address;
  logic                  addr_valid;
  logic                  page_cross;
  logic                  busy;

  modport master (
    output req, src, idx_sel, always_fix,
    input  address, addr_valid, page_cross, busy
  );

  modport slave (
    input  req, src, idx_sel, always_fix,
    output address, addr_valid, page_cross, busy
  );

endinterface

// File: rtl/address_gen_adder.sv
// Low-byte index add with carry-out and optional +1, plus an incremented copy of the high byte.
module addr_adder #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_lo,
  input  logic [DATA_W-1:0] i_idx,
  input  logic [DATA_W-1:0] i_hi,
  input  logic              i_plusOne,
  output logic [DATA_W-1:0] o_lo,
  output logic              o_carry,
  output logic [DATA_W-1:0] o_hiInc
);

  logic [DATA_W:0] w_sum;

  assign w_sum   = {1'b0, i_lo} + {1'b0, i_idx} + (DATA_W+1)'(i_plusOne);
  assign o_lo    = w_sum[DATA_W-1:0];
  assign o_carry = w_sum[DATA_W];
  assign o_hiInc = i_hi + DATA_W'(1);

endmodule

// File: rtl/address_gen.sv
// Registered 6502 effective-address generator with a one-cycle page-crossing fix-up state.
module address_gen
  import cpu6502_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] ZP_PAGE     = DATA_W'(DEF_ZP_PAGE),
  parameter logic [DATA_W-1:0] STACK_PAGE  = DATA_W'(DEF_STACK_PAGE),
  parameter logic [DATA_W-1:0] VEC_PAGE    = DATA_W'(DEF_VEC_PAGE),
  parameter bit                JMP_IND_BUG = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                ld_oper_lo,
  input  logic                ld_oper_hi,
  input  logic                ld_ptr_lo,
  input  logic                ld_ptr_hi,
  input  logic [2*DATA_W-1:0] pc,
  input  logic [DATA_W-1:0]   sp,
  input  logic [DATA_W-1:0]   vec_lo,
  input  logic [DATA_W-1:0]   x_reg,
  input  logic [DATA_W-1:0]   y_reg,
  address_gen_if.slave        bus
);

  localparam int ADDR_W = 2 * DATA_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FIX  = 1'b1;

  logic [DATA_W-1:0] r_operLo, r_operHi, r_ptrLo, r_ptrHi;
  logic [DATA_W-1:0] r_fixHi;
  logic [ADDR_W-1:0] r_address;
  logic              r_addrValid, r_pageCross, r_busy;
  logic [0:0]        r_state;

  logic [DATA_W-1:0] w_idx, w_addLo, w_addIdx, w_addHi;
  logic              w_plusOne;
  logic [DATA_W-1:0] w_sumLo, w_hiInc;
  logic              w_carry;
  logic [ADDR_W-1:0] w_issueAddr;
  logic              w_fixSrc, w_needFix;

  always_comb begin
    unique case (bus.idx_sel)
      IDX_X:   w_idx = x_reg;
      IDX_Y:   w_idx = y_reg;
      default: w_idx = '0;
    endcase
  end

  always_comb begin
    w_addLo   = r_operLo;
    w_addHi   = r_operHi;
    w_addIdx  = w_idx;
    w_plusOne = 1'b0;
    case (bus.src)
      SRC_IND: begin
        w_addLo = r_ptrLo;
        w_addHi = r_ptrHi;
      end
      SRC_ZPTR_HI: w_plusOne = 1'b1;
      SRC_IND_HI: begin
        w_addIdx  = '0;
        w_plusOne = 1'b1;
      end
      default: ;
    endcase
  end

  addr_adder #(.DATA_W(DATA_W)) u_adder (
    .i_lo      (w_addLo),
    .i_idx     (w_addIdx),
    .i_hi      (w_addHi),
    .i_plusOne (w_plusOne),
    .o_lo      (w_sumLo),
    .o_carry   (w_carry),
    .o_hiInc   (w_hiInc)
  );

  // Page-relative sources drop the carry; ABS/IND defer it to the fix-up cycle.
  always_comb begin
    w_issueAddr = '0;
    w_fixSrc    = is_fixup_src(bus.src);
    case (bus.src)
      SRC_PC:                             w_issueAddr = pc;
      SRC_ZP, SRC_ZPTR_LO, SRC_ZPTR_HI:   w_issueAddr = {ZP_PAGE, w_sumLo};
      SRC_ABS, SRC_IND:                   w_issueAddr = {w_addHi, w_sumLo};
      SRC_STACK:                          w_issueAddr = {STACK_PAGE, sp};
      SRC_VECTOR:                         w_issueAddr = {VEC_PAGE, vec_lo};
      SRC_IND_HI:
        w_issueAddr = {(!JMP_IND_BUG && w_carry) ? w_hiInc : w_addHi, w_sumLo};
      default:                            w_issueAddr = '0;
    endcase
  end

  assign w_needFix = w_fixSrc && (w_carry || bus.always_fix);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_operLo <= '0;
      r_operHi <= '0;
      r_ptrLo  <= '0;
      r_ptrHi  <= '0;
    end else begin
      if (ld_oper_lo) r_operLo <= data_in;
      if (ld_oper_hi) r_operHi <= data_in;
      if (ld_ptr_lo)  r_ptrLo  <= data_in;
      if (ld_ptr_hi)  r_ptrHi  <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_address   <= '0;
      r_addrValid <= 1'b0;
      r_pageCross <= 1'b0;
      r_busy      <= 1'b0;
      r_fixHi     <= '0;
    end else begin
      r_addrValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req) begin
            r_address   <= w_issueAddr;
            r_addrValid <= 1'b1;
            r_pageCross <= w_fixSrc && w_carry;
            r_fixHi     <= w_carry ? w_hiInc : w_addHi;
            if (w_needFix) begin
              r_busy  <= 1'b1;
              r_state <= ST_FIX;
            end
          end
        end
        default: begin
          r_address   <= {r_fixHi, r_address[DATA_W-1:0]};
          r_addrValid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.address    = r_address;
  assign bus.addr_valid = r_addrValid;
  assign bus.page_cross = r_pageCross;
  assign bus.busy       = r_busy;

endmodule

// File: doc/address_gen.md
Name: address_gen

Overview:
- Parametrised, registered effective-address generator for the 6502 core; successor to the combinational address select.
- Holds operand and pointer byte registers and adds X/Y indexing.
- Handles zero-page wrap, stack and vector pages, and the JMP-indirect page bug.
- Runs a page-crossing fix-up state machine that inserts the extra bus cycle the sequencer needs.

Parameters:
- DATA_W, 8: byte width. The address is 2*DATA_W, a localparam, not overridable.
- ZP_PAGE, 8'h00: high byte for zero-page accesses.
- STACK_PAGE, 8'h01: high byte for stack accesses.
- VEC_PAGE, 8'hFF: high byte for vector fetches.
- JMP_IND_BUG, 1: 1 means the IND_HI low-byte increment does not carry into the high byte; 0 means full carry.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  DATA_W  byte from the data bus, used for the register loads.
- ld_oper_lo / ld_oper_hi  in  1  load the operand low/high byte from data_in.
- ld_ptr_lo / ld_ptr_hi  in  1  load the fetched-pointer low/high byte from data_in.
- pc  in  2*DATA_W  current program counter.
- sp  in  DATA_W  stack pointer.
- vec_lo  in  DATA_W  vector low byte (FA/FC/FE).
- x_reg, y_reg  in  DATA_W  index registers.
- idx_sel  in  2  00 none, 01 X, 10 Y, 11 none.
- src  in  4  address source (encodings under Behaviour).
- req  in  1  one-cycle request to issue a new address.
- always_fix  in  1  force the fix-up cycle even with no carry (indexed write/RMW).
- address  out  2*DATA_W  registered bus address.
- addr_valid  out  1  address is a new issued value this cycle.
- page_cross  out  1  indexed add carried out of the low byte (registered with the first address).
- busy  out  1  fix-up pending or in progress; req must be held low.

Behaviour:
- Reset (async, rst_n=0): address=0, addr_valid=0, page_cross=0, busy=0, all byte registers 0, state IDLE.
- Operand and pointer register loads happen on the clock edge, independent of state.
- If a load and a req coincide, the req uses the pre-load register value.
- idx = selected index byte.
- Source encodings:
  - 0 PC: {pc}, no index.
  - 1 ZP: {ZP_PAGE, oper_lo+idx mod 2^DATA_W}, never carries.
  - 2 ABS: {oper_hi, oper_lo}+idx, fix-up capable.
  - 3 ZPTR_LO: {ZP_PAGE, oper_lo+idx}, wraps.
  - 4 ZPTR_HI: {ZP_PAGE, oper_lo+idx+1}, wraps; so pointer FF gives 00FF then 0000.
  - 5 IND: {ptr_hi, ptr_lo}+idx, fix-up capable.
  - 6 STACK: {STACK_PAGE, sp}.
  - 7 VECTOR: {VEC_PAGE, vec_lo}.
  - 8 IND_HI: {oper_hi, oper_lo+1}. With JMP_IND_BUG=1 there is no carry, so 02FF gives 0200. With JMP_IND_BUG=0 the carry propagates, giving 0300.
  - 9-15: address=0, addr_valid still pulses.
- States: IDLE, FIX.
- IDLE, req=1: next edge address = {hi, (lo+idx) mod 256}, addr_valid=1.
  - page_cross = carry, only for ABS/IND; 0 for all other sources.
  - If the source is ABS/IND and (carry or always_fix): busy=1, go to FIX.
- IDLE, req=0: address holds, addr_valid=0, page_cross holds.
- FIX, one cycle: next edge address = {hi+carry mod 256, same low byte}, addr_valid=1, busy=0, return to IDLE. page_cross is unchanged.
- Latency: one cycle from req to address, two cycles to the corrected address when fixing up.
- The high byte wraps at FF: FFxx+carry gives 00xx, with no other flag.
- req during FIX is ignored and is a sequencer protocol violation (the bench asserts on it).
- Reset mid-FIX: returns to IDLE immediately, with no fix-up output.

Decomposition:
- Shared package cpu6502_pkg holds:
  - src encodings (SRC_PC … SRC_IND_HI).
  - idx_sel encodings.
  - Default page constants.
- One natural sub-module: addr_adder (combinational DATA_W low-byte add with carry-out, optional +1, and a high-byte increment). Instantiated once for the indexed/pointer sum.
- The FSM and registers stay in address_gen.

Test Plan:
- Reset with ld/req toggling -> address=0000, addr_valid=0, busy=0; after release, req SRC_PC with pc=C123 -> next cycle address=C123, valid=1.
- oper=12F0, X=20, src=ABS, req -> cycle 1 address=1210, page_cross=1, busy=1; cycle 2 address=1310, valid=1, busy=0.
- oper=1200, X=05, always_fix=1, ABS -> 1205 then 1205 again, page_cross=0.
- ZP wrap: oper_lo=F0, X=20, src=ZP -> 0010. ZPTR_LO/ZPTR_HI with oper_lo=FF, idx none -> 00FF then 0000.
- ptr=FF80, Y=90, IND -> FF10 with page_cross=1, then 0010 (high byte wraps).
- IND_HI with oper=02FF -> 0200 when JMP_IND_BUG=1, 0300 when JMP_IND_BUG=0.
- rst_n low during FIX -> address=0000, busy=0 asynchronously; no fix-up pulse after release.
